// File: rtl/name_arb_pkg.sv
// Shared types and sizing for the name arbiter: FSM encoding, datapath widths
// and the default idle-timeout threshold.
package name_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    SAMPLE = 2'd3
  } state_t;

  localparam int IDLE_TIMEOUT_DEF = 16;
  localparam int CHAR_W           = 8;
  localparam int LEN_W            = 8;

endpackage

// File: rtl/name_arb_rr.sv
// Two-way round-robin pick: on contention the requester not served last wins,
// otherwise whichever single requester is valid.
module name_arb_rr (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (valid == 2'b11) grant = ~last_grant;
    else if (valid[1])  grant = 1'b1;
  end

endmodule

// File: rtl/name_arbiter.sv
// Shares one string recognizer between two character streams, one whole string
// at a time, and reports length/match/abort for each finished string.
//
// state  | meaning
// IDLE   | waiting for any requester; arbitration registered on exit
// CLEAR  | one-cycle recognizer clear, length/idle counters zeroed
// STREAM | granted requester feeds the recognizer until last or timeout
// SAMPLE | result strobe; rec_out is valid this cycle
module name_arbiter
  import name_arb_pkg::*;
#(
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_last,
  input  logic [CHAR_W-1:0] req_char0,
  input  logic [CHAR_W-1:0] req_char1,
  output logic [1:0]        req_ready,
  output logic [CHAR_W-1:0] rec_name,
  output logic              rec_en,
  output logic              rec_reset,
  input  logic              rec_out,
  output logic              res_valid,
  output logic              res_id,
  output logic              res_match,
  output logic              res_abort,
  output logic [LEN_W-1:0]  res_len
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  state_t             state, state_nxt;
  logic               grant, last_grant, rr_grant;
  logic [LEN_W-1:0]   len_cnt, len_q;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               abort, id_q, match_q, abort_q;
  logic               valid_g, last_g, timeout;

  name_arb_rr u_rr (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (rr_grant)
  );

  assign valid_g = req_valid[grant];
  assign last_g  = req_last[grant];
  // This stalled cycle is the IDLE_TIMEOUT-th consecutive one
  assign timeout = (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      len_cnt    <= '0;
      idle_cnt   <= '0;
      abort      <= 1'b0;
      id_q       <= 1'b0;
      match_q    <= 1'b0;
      abort_q    <= 1'b0;
      len_q      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (|req_valid) grant <= rr_grant;
        CLEAR: begin
          len_cnt  <= '0;
          idle_cnt <= '0;
          abort    <= 1'b0;
        end
        STREAM: begin
          if (valid_g) begin
            if (len_cnt != '1) len_cnt <= len_cnt + 1'b1;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
            if (timeout) abort <= 1'b1;
          end
        end
        SAMPLE: begin
          last_grant <= grant;
          id_q       <= grant;
          match_q    <= rec_out & ~abort;
          abort_q    <= abort;
          len_q      <= len_cnt;
        end
        default: ;
      endcase
    end
  end

  // Result fields show live values during SAMPLE and hold them afterwards
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rec_name  = '0;
    rec_en    = 1'b0;
    rec_reset = reset;
    res_valid = 1'b0;
    res_id    = id_q;
    res_match = match_q;
    res_abort = abort_q;
    res_len   = len_q;
    case (state)
      IDLE: if (|req_valid) state_nxt = CLEAR;
      CLEAR: begin
        rec_reset = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        req_ready = grant ? 2'b10 : 2'b01;
        rec_name  = grant ? req_char1 : req_char0;
        rec_en    = valid_g;
        if (valid_g && last_g)      state_nxt = SAMPLE;
        else if (!valid_g && timeout) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        res_valid = 1'b1;
        res_id    = grant;
        res_match = rec_out & ~abort;
        res_abort = abort;
        res_len   = len_cnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_name_arbiter.sv
// Directed bench for name_arbiter: reset, single string, round-robin, gaps,
// idle timeout, mid-string reset and length saturation.
module tb_name_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid, req_last, req_ready;
  logic [7:0] req_char0, req_char1, rec_name, res_len;
  logic       rec_en, rec_reset, rec_out;
  logic       res_valid, res_id, res_match, res_abort;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  name_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_char0 (req_char0),
    .req_char1 (req_char1),
    .req_ready (req_ready),
    .rec_name  (rec_name),
    .rec_en    (rec_en),
    .rec_reset (rec_reset),
    .rec_out   (rec_out),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_match (res_match),
    .res_abort (res_abort),
    .res_len   (res_len)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    n_checks++; if (rec_reset !== 1'b1) $display("FAIL rst_rec_reset got %0b exp 1", rec_reset); else n_pass++;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL rst_ready got %b exp 00", req_ready); else n_pass++;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %0b exp 0", res_valid); else n_pass++;
    n_checks++; if (res_len !== 8'd0) $display("FAIL rst_res_len got %0d exp 0", res_len); else n_pass++;
    n_checks++; if ({res_id, res_match, res_abort} !== 3'b000) $display("FAIL rst_res_flags got %b exp 000", {res_id, res_match, res_abort}); else n_pass++;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (rec_reset !== 1'b0) $display("FAIL rst_release_rec_reset got %0b exp 0", rec_reset); else n_pass++;
    n_checks++; if ({rec_en, rec_name} !== 9'h000) $display("FAIL rst_idle_rec got %h exp 000", {rec_en, rec_name}); else n_pass++;
  endtask

  task automatic test_single();
    logic [7:0] s [4];
    s = '{8'h73, 8'h32, 8'h73, 8'h2e};
    cyc();
    req_valid = 2'b01; req_char0 = s[0];
    @(negedge clk);
    n_checks++; if ({req_ready, rec_en} !== 3'b000) $display("FAIL single_idle got %b exp 000", {req_ready, rec_en}); else n_pass++;
    cyc();
    @(negedge clk);
    n_checks++; if ({rec_reset, req_ready} !== 3'b100) $display("FAIL single_clear got %b exp 100", {rec_reset, req_ready}); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cyc();
      req_char0 = s[i]; req_last = (i == 3) ? 2'b01 : 2'b00;
      @(negedge clk);
      n_checks++; if ({req_ready, rec_en, rec_reset} !== 4'b0110) $display("FAIL single_stream%0d_ctl got %b exp 0110", i, {req_ready, rec_en, rec_reset}); else n_pass++;
      n_checks++; if (rec_name !== s[i]) $display("FAIL single_stream%0d_name got %h exp %h", i, rec_name, s[i]); else n_pass++;
      n_checks++; if (res_valid !== 1'b0) $display("FAIL single_stream%0d_early got %0b exp 0", i, res_valid); else n_pass++;
    end
    cyc();
    req_valid = 2'b00; req_last = 2'b00; rec_out = 1'b1;
    @(negedge clk);
    n_checks++; if (res_valid !== 1'b1) $display("FAIL single_res_valid got %0b exp 1", res_valid); else n_pass++;
    n_checks++; if (res_len !== 8'd4) $display("FAIL single_res_len got %0d exp 4", res_len); else n_pass++;
    n_checks++; if ({res_id, res_match, res_abort} !== 3'b010) $display("FAIL single_res_flags got %b exp 010", {res_id, res_match, res_abort}); else n_pass++;
    n_checks++; if (rec_name !== 8'h00) $display("FAIL single_sample_name got %h exp 00", rec_name); else n_pass++;
    cyc();
    rec_out = 1'b0;
    @(negedge clk);
    n_checks++; if (res_valid !== 1'b0) $display("FAIL single_strobe_len got %0b exp 0", res_valid); else n_pass++;
    n_checks++; if ({res_len, res_id, res_match, res_abort} !== {8'd4, 3'b010}) $display("FAIL single_hold got %h exp %h", {res_len, res_id, res_match, res_abort}, {8'd4, 3'b010}); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ready;
    logic       exp_id;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_id    = (k == 1);
      exp_ready = exp_id ? 2'b10 : 2'b01;
      cyc();
      req_valid = 2'b11; req_last = 2'b11; req_char0 = 8'h30; req_char1 = 8'h31;
      @(negedge clk);
      n_checks++; if (req_ready !== 2'b00) $display("FAIL rr%0d_idle_ready got %b exp 00", k, req_ready); else n_pass++;
      cyc();
      @(negedge clk);
      n_checks++; if (rec_reset !== 1'b1) $display("FAIL rr%0d_clear got %0b exp 1", k, rec_reset); else n_pass++;
      cyc();
      @(negedge clk);
      n_checks++; if (req_ready !== exp_ready) $display("FAIL rr%0d_ready got %b exp %b", k, req_ready, exp_ready); else n_pass++;
      n_checks++; if (rec_name !== (exp_id ? 8'h31 : 8'h30)) $display("FAIL rr%0d_name got %h exp %h", k, rec_name, exp_id ? 8'h31 : 8'h30); else n_pass++;
      cyc();
      rec_out = (k == 1);
      @(negedge clk);
      n_checks++; if ({res_valid, res_id} !== {1'b1, exp_id}) $display("FAIL rr%0d_res_id got %b exp %b", k, {res_valid, res_id}, {1'b1, exp_id}); else n_pass++;
      n_checks++; if (res_len !== 8'd1) $display("FAIL rr%0d_res_len got %0d exp 1", k, res_len); else n_pass++;
      n_checks++; if (res_match !== (k == 1)) $display("FAIL rr%0d_res_match got %0b exp %0b", k, res_match, (k == 1)); else n_pass++;
    end
    req_valid = 2'b00; req_last = 2'b00; rec_out = 1'b0;
  endtask

  task automatic test_gap();
    bit [6:0] vpat = 7'b1100011;
    cyc();
    req_valid = 2'b10; req_char1 = 8'h41;
    cyc();
    for (int i = 0; i < 7; i++) begin
      cyc();
      req_valid = {vpat[i], 1'b0}; req_char1 = 8'h41 + 8'(i);
      req_last  = (i == 6) ? 2'b10 : 2'b00;
      @(negedge clk);
      n_checks++; if (req_ready !== 2'b10) $display("FAIL gap%0d_ready got %b exp 10", i, req_ready); else n_pass++;
      n_checks++; if (rec_en !== vpat[i]) $display("FAIL gap%0d_rec_en got %0b exp %0b", i, rec_en, vpat[i]); else n_pass++;
    end
    cyc();
    req_valid = 2'b00; req_last = 2'b00; rec_out = 1'b0;
    @(negedge clk);
    n_checks++; if ({res_valid, res_id, res_abort} !== 3'b110) $display("FAIL gap_res_flags got %b exp 110", {res_valid, res_id, res_abort}); else n_pass++;
    n_checks++; if (res_len !== 8'd4) $display("FAIL gap_res_len got %0d exp 4", res_len); else n_pass++;
  endtask

  task automatic test_timeout_and_reset();
    cyc();
    req_valid = 2'b01; req_char0 = 8'h7a;
    cyc();
    req_valid = 2'b00;
    for (int i = 0; i < 16; i++) begin
      cyc();
      @(negedge clk);
      n_checks++; if ({req_ready, rec_en, res_valid} !== 4'b0100) $display("FAIL stall%0d got %b exp 0100", i, {req_ready, rec_en, res_valid}); else n_pass++;
    end
    cyc();
    rec_out = 1'b1;
    @(negedge clk);
    n_checks++; if ({res_valid, res_abort, res_match, res_id} !== 4'b1100) $display("FAIL timeout_flags got %b exp 1100", {res_valid, res_abort, res_match, res_id}); else n_pass++;
    n_checks++; if (res_len !== 8'd0) $display("FAIL timeout_len got %0d exp 0", res_len); else n_pass++;
    cyc();
    rec_out = 1'b0; req_valid = 2'b11; req_char1 = 8'h55;
    cyc();
    cyc();
    @(negedge clk);
    n_checks++; if ({req_ready, rec_en} !== 3'b101) $display("FAIL rearb_ready got %b exp 101", {req_ready, rec_en}); else n_pass++;
    cyc();
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (rec_reset !== 1'b1) $display("FAIL midrst_rec_reset got %0b exp 1", rec_reset); else n_pass++;
    cyc();
    @(negedge clk);
    n_checks++; if ({rec_reset, req_ready, res_valid, rec_name} !== {1'b1, 2'b00, 1'b0, 8'h00}) $display("FAIL midrst_idle got %h exp %h", {rec_reset, req_ready, res_valid, rec_name}, {1'b1, 2'b00, 1'b0, 8'h00}); else n_pass++;
    cyc();
    reset = 1'b0; req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if ({res_valid, res_len, res_abort} !== 10'd0) $display("FAIL midrst_after got %h exp 000", {res_valid, res_len, res_abort}); else n_pass++;
    cyc();
    @(negedge clk);
    n_checks++; if ({res_valid, req_ready} !== 3'b000) $display("FAIL midrst_quiet got %b exp 000", {res_valid, req_ready}); else n_pass++;
  endtask

  task automatic test_saturate();
    cyc();
    req_valid = 2'b01; req_char0 = 8'h61;
    cyc();
    for (int i = 0; i < 300; i++) begin
      cyc();
      req_last = (i == 299) ? 2'b01 : 2'b00;
    end
    cyc();
    req_valid = 2'b00; req_last = 2'b00;
    @(negedge clk);
    n_checks++; if ({res_valid, res_id, res_abort} !== 3'b100) $display("FAIL sat_flags got %b exp 100", {res_valid, res_id, res_abort}); else n_pass++;
    n_checks++; if (res_len !== 8'd255) $display("FAIL sat_len got %0d exp 255", res_len); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; req_last = 2'b00;
    req_char0 = 8'h00; req_char1 = 8'h00; rec_out = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_gap();
    test_timeout_and_reset();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/name_arbiter.md
NAME_ARBITER -- requirements
Module: name_arbiter

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 req_valid  in  2  per-requester character valid (bit i = requester i).
REQ-004 req_last  in  2  per-requester flag: current character ends the string.
REQ-005 req_char0 / req_char1  in  8 each  ASCII character from requester 0 / 1.
REQ-006 req_ready  out  2  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-007 rec_name  out  8  character to the shared recognizer.
REQ-008 rec_en  out  1  recognizer advance enable; the recognizer consumes rec_name only when rec_en=1.
REQ-009 rec_reset  out  1  synchronous clear of the recognizer.
REQ-010 rec_out  in  1  recognizer match flag, valid the cycle after the last consumed character.
REQ-011 res_valid  out  1  one-cycle result strobe.
REQ-012 res_id  out  1  requester that owned the finished string.
REQ-013 res_match  out  1  sampled rec_out; 0 on abort.
REQ-014 res_abort  out  1  string terminated by idle timeout.
REQ-015 res_len  out  8  characters transferred, saturating at 255.
REQ-016 IDLE_TIMEOUT, default 16: consecutive granted-but-invalid STREAM cycles before abort.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, STREAM, SAMPLE.
REQ-018 IDLE: req_ready=0, rec_en=0; if any req_valid, register grant via round-robin and go to CLEAR; otherwise stay.
REQ-019 Round-robin: with both valid, the requester not granted last SHALL win; after reset, requester 0 wins.
REQ-020 CLEAR: rec_reset=1 for exactly one cycle, req_ready=0; next state STREAM; length and idle counters zeroed.
REQ-021 STREAM: req_ready[grant]=1, other bit 0; rec_name=req_char of grant; rec_en=req_valid[grant] (combinational).
REQ-022 Each STREAM transfer increments res_len counter (saturating at 255) and clears the idle counter.
REQ-023 Transfer with req_last[grant]=1 SHALL move to SAMPLE.
REQ-024 Cycle in STREAM with req_valid[grant]=0 increments idle counter; reaching IDLE_TIMEOUT moves to SAMPLE with abort flag set.
REQ-025 SAMPLE: res_valid=1, res_id=grant, res_match=rec_out (0 if abort), res_abort=abort flag, res_len=counter; last-granted pointer updated; next state IDLE.
REQ-026 Latency: req_valid seen in IDLE at cycle N -> CLEAR at N+1 -> first transfer earliest N+2; res_valid exactly one cycle after the last transfer.
REQ-027 Non-granted requester SHALL see req_ready=0 for the whole string, even if it asserts req_last.
REQ-028 res_* outputs other than res_valid hold their last values between strobes; rec_name=8'h00 outside STREAM.
REQ-029 A single-character string (valid+last on first STREAM cycle) SHALL yield res_len=1.

Reset
REQ-030 reset SHALL force IDLE, grant=0, last-granted=1 (so requester 0 wins next), counters 0, abort 0, res_*=0.
REQ-031 rec_reset SHALL be high whenever reset is high; a reset mid-string discards it with no res_valid.

Structure
REQ-032 Package name_arb_pkg SHALL hold the state enum, IDLE_TIMEOUT default, CHAR_W=8, LEN_W=8.
REQ-033 The 2-way round-robin decision SHALL be a sub-module name_arb_rr (inputs valid[1:0], last-granted; output grant).

Verification
REQ-034 Req0 sends "s2s." alone -> CLEAR one cycle, four transfers, res_valid one cycle later with res_id=0, res_len=4, res_match=rec_out.
REQ-035 Both valid in same IDLE cycle after reset -> req0 served first, then req1; third contention -> req0 again.
REQ-036 Req1 deasserts valid for 3 cycles mid-string -> rec_en low those cycles, no abort, res_len counts only transfers.
REQ-037 Req0 stalls 16 cycles in STREAM -> res_valid, res_abort=1, res_match=0, next string re-arbitrated.
REQ-038 reset asserted mid-STREAM -> next cycle IDLE, rec_reset=1, req_ready=0, no res_valid.
REQ-039 300-character string -> res_len=255 saturated.
